ps2_scancode_ctrl: RTL and testbench
====================================

// Module: ps2_scancode_ctrl
// PURPOSE
//   Sequencer between the PS/2 receiver FIFO and the display path. Pops bytes via
//   the receiver's ready/nextdata_n handshake and parses the prefix sequence
//   (E0 extended, F0 break). Tracks key state and counts distinct key presses.
//   Recovers from receiver overflow and drives the display digit-select mask.
// PARAMETERS
//   CNT_W   8   width of press counter; wraps modulo 2**CNT_W
// PORTS
//   clk             in   1      clock, all logic on rising edge
//   reset           in   1      synchronous, active-high
//   kbd_ready       in   1      receiver FIFO non-empty; kbd_data valid
//   kbd_overflow    in   1      receiver FIFO overflowed
//   kbd_data        in   8      byte at FIFO head
//   kbd_nextdata_n  out  1      active-low pop strobe, exactly 1 cycle per byte
//   kbd_clrn        out  1      active-low receiver clear
//   key_code        out  8      code of most recent make event (prefixes stripped)
//   key_ext         out  1      key_code was E0-prefixed
//   key_down        out  1      key_code currently held
//   key_valid       out  1      1-cycle pulse on new press or release
//   press_cnt       out  CNT_W  count of new presses, excluding typematic repeats
//   kbd_err         out  1      sticky: overflow seen since reset
//   disp_select     out  8      digit enable mask for segment display
// BEHAVIOUR
//   Reset values: kbd_nextdata_n=1, kbd_clrn=0, key_code=0, key_ext=0, key_down=0,
//     key_valid=0, press_cnt=0, kbd_err=0, state=IDLE, ext_pend=0, brk_pend=0.
//   kbd_clrn=1 in every state except FLUSH and the reset cycle.
//   FSM states: IDLE, POP, EVAL, FLUSH. All outputs are registered.
//   IDLE:  kbd_overflow=1 -> FLUSH. Overflow has priority over kbd_ready.
//          Else kbd_ready=1 -> latch kbd_data into byte_r, drive kbd_nextdata_n=0
//          on the next cycle, go to POP.
//   POP:   kbd_nextdata_n=0 for this single cycle; always -> EVAL.
//   EVAL:  kbd_nextdata_n=1. Decode byte_r:
//          8'hE0 -> ext_pend=1.
//          8'hF0 -> brk_pend=1.
//          other, brk_pend=1 (release): if byte_r==key_code and ext_pend==key_ext,
//            then key_down=0 and key_valid=1. Otherwise ignore.
//          other, brk_pend=0 (make): if key_down=1, byte_r==key_code and
//            ext_pend==key_ext, it is a typematic repeat: no change, no pulse.
//            Otherwise key_code=byte_r, key_ext=ext_pend, key_down=1,
//            press_cnt+=1 (wraps), key_valid=1.
//          Non-prefix byte clears ext_pend and brk_pend. Always -> IDLE.
//   FLUSH: kbd_clrn=0 for 1 cycle. kbd_err=1; clear ext_pend, brk_pend, key_down.
//          key_code and press_cnt are kept. -> IDLE.
//   Throughput: at most 1 byte per 3 cycles (IDLE->POP->EVAL). kbd_ready is
//     sampled only in IDLE, so the post-pop ready update is never double-popped.
//   Overflow in POP/EVAL: the current byte completes; FLUSH is taken from IDLE.
//   Reset mid-sequence: all pending prefix state is lost; no pop is issued.
//   disp_select: bits[1:0]=key_down (code digits); bits[4:2]=(press_cnt!=0)
//     (count digits); bits[7:5]=0.
// STRUCTURE
//   Shared package ps2_pkg: SC_EXT=8'hE0, SC_BRK=8'hF0, state encoding
//     (IDLE/POP/EVAL/FLUSH, 2-bit).
//   Single module, no sub-module. Binary-to-BCD for press_cnt stays downstream.
// TESTING
//   1 Bytes 1C, F0, 1C -> key_valid pulses twice; key_code=1C; press_cnt=1;
//     key_down ends 0; exactly 3 single-cycle nextdata_n pulses.
//   2 Bytes 1C, 1C, 1C (repeat), F0, 1C -> press_cnt=1; key_valid pulses twice.
//   3 Bytes E0, 75, E0, F0, 75 -> key_code=75, key_ext=1; press_cnt=1;
//     key_down=0 at end.
//   4 Bytes 1C, 32 -> press_cnt=2, key_code=32; F0, 1C then ignored (key_down stays 1).
//   5 kbd_overflow=1 with kbd_ready=1 in IDLE -> no pop; kbd_clrn=0 for 1 cycle;
//     kbd_err=1; key_down=0.
//   6 Preload press_cnt=FF (CNT_W=8) then new press -> press_cnt=00. Reset
//     asserted during POP -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode sequencer.
// Holds the prefix scancodes and the sequencer state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        EVAL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/ps2_scancode_ctrl.sv
// Pops bytes from the PS/2 receiver FIFO, strips E0/F0 prefixes,
// tracks key state, counts presses and recovers from overflow.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    input  logic [7:0]       kbd_data,
    output logic             kbd_nextdata_n,
    output logic             kbd_clrn,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             key_valid,
    output logic [CNT_W-1:0] press_cnt,
    output logic             kbd_err,
    output logic [7:0]       disp_select
);

    state_t           state, state_nx;
    logic [7:0]       byte_r, byte_nx;
    logic             ext_pend, ext_nx;
    logic             brk_pend, brk_nx;
    logic [7:0]       code_nx;
    logic             kext_nx, down_nx, valid_nx, err_nx;
    logic             nd_nx, clrn_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [7:0]       disp_nx;
    logic             match;
    logic             is_ext, is_brk;

    assign match  = (byte_r == key_code) && (ext_pend == key_ext);
    assign is_ext = (byte_r == SC_EXT);
    assign is_brk = (byte_r == SC_BRK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            byte_r         <= 8'h00;
            ext_pend       <= 1'b0;
            brk_pend       <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_down       <= 1'b0;
            key_valid      <= 1'b0;
            press_cnt      <= '0;
            kbd_err        <= 1'b0;
            kbd_nextdata_n <= 1'b1;
            kbd_clrn       <= 1'b0;
            disp_select    <= 8'h00;
        end else begin
            state          <= state_nx;
            byte_r         <= byte_nx;
            ext_pend       <= ext_nx;
            brk_pend       <= brk_nx;
            key_code       <= code_nx;
            key_ext        <= kext_nx;
            key_down       <= down_nx;
            key_valid      <= valid_nx;
            press_cnt      <= cnt_nx;
            kbd_err        <= err_nx;
            kbd_nextdata_n <= nd_nx;
            kbd_clrn       <= clrn_nx;
            disp_select    <= disp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        byte_nx  = byte_r;
        ext_nx   = ext_pend;
        brk_nx   = brk_pend;
        code_nx  = key_code;
        kext_nx  = key_ext;
        down_nx  = key_down;
        valid_nx = 1'b0;
        cnt_nx   = press_cnt;
        err_nx   = kbd_err;
        nd_nx    = 1'b1;
        clrn_nx  = 1'b1;
        unique case (state)
            IDLE: begin
                if (kbd_overflow) begin
                    state_nx = FLUSH;
                    clrn_nx  = 1'b0;
                end else if (kbd_ready) begin
                    byte_nx  = kbd_data;
                    nd_nx    = 1'b0;
                    state_nx = POP;
                end
            end
            POP: begin
                state_nx = EVAL;
            end
            EVAL: begin
                state_nx = IDLE;
                unique case (1'b1)
                    is_ext: ext_nx = 1'b1;
                    is_brk: brk_nx = 1'b1;
                    default: begin
                        ext_nx = 1'b0;
                        brk_nx = 1'b0;
                        if (brk_pend) begin
                            if (match) begin
                                down_nx  = 1'b0;
                                valid_nx = 1'b1;
                            end
                        // a held key re-sending its make code is typematic
                        end else if (!(key_down && match)) begin
                            code_nx  = byte_r;
                            kext_nx  = ext_pend;
                            down_nx  = 1'b1;
                            cnt_nx   = press_cnt + CNT_W'(1);
                            valid_nx = 1'b1;
                        end
                    end
                endcase
            end
            FLUSH: begin
                err_nx   = 1'b1;
                ext_nx   = 1'b0;
                brk_nx   = 1'b0;
                down_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        disp_nx = {3'b000, {3{cnt_nx != '0}}, {2{down_nx}}};
    end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for ps2_scancode_ctrl with a small FIFO model
// standing in for the PS/2 receiver.
module tb_ps2_scancode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_nextdata_n;
    logic       kbd_clrn;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       key_valid;
    logic [7:0] press_cnt;
    logic       kbd_err;
    logic [7:0] disp_select;

    int errs = 0;
    int checks = 0;

    logic [7:0] mem [64];
    int wr = 0;
    int rd = 0;

    int valid_n = 0;
    int pulses = 0;
    int run = 0;
    int max_run = 0;
    int clrn_low = 0;
    logic nd_prev = 1'b1;

    int b_valid, b_pulses, b_clrn;

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(.CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .kbd_ready      (kbd_ready),
        .kbd_overflow   (kbd_overflow),
        .kbd_data       (kbd_data),
        .kbd_nextdata_n (kbd_nextdata_n),
        .kbd_clrn       (kbd_clrn),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_down       (key_down),
        .key_valid      (key_valid),
        .press_cnt      (press_cnt),
        .kbd_err        (kbd_err),
        .disp_select    (disp_select)
    );

    // receiver model plus event counters, all sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            valid_n += int'(key_valid);
            if (!kbd_nextdata_n && nd_prev) pulses++;
            if (!kbd_nextdata_n) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            clrn_low += int'(!kbd_clrn);
        end
        nd_prev = kbd_nextdata_n;
        if (!kbd_nextdata_n && rd != wr) rd++;
        if (!kbd_clrn) rd = wr;
        kbd_ready = (rd != wr);
        kbd_data  = kbd_ready ? mem[rd % 64] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #1;
        mem[wr % 64] = b;
        wr++;
    endtask

    task automatic drain();
        int n = 0;
        while (rd != wr && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(rd == wr), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        b_valid  = valid_n;
        b_pulses = pulses;
        b_clrn   = clrn_low;
        max_run  = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_nd", 32'(kbd_nextdata_n), 32'd1);
        chk("rst_clrn", 32'(kbd_clrn), 32'd0);
        chk("rst_code", 32'(key_code), 32'h00);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        chk("rst_err", 32'(kbd_err), 32'd0);
        chk("rst_disp", 32'(disp_select), 32'h00);
        do_reset();
        chk("clrn_idle", 32'(kbd_clrn), 32'd1);

        // 1: make, break
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        chk("t1_valid", 32'(valid_n - b_valid), 32'd2);
        chk("t1_code", 32'(key_code), 32'h1C);
        chk("t1_cnt", 32'(press_cnt), 32'd1);
        chk("t1_down", 32'(key_down), 32'd0);
        chk("t1_pops", 32'(pulses - b_pulses), 32'd3);
        chk("t1_width", 32'(max_run), 32'd1);
        chk("t1_disp", 32'(disp_select), 32'h1C);

        // 2: typematic repeats
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C);
        push(8'hF0); push(8'h1C);
        drain();
        chk("t2_cnt", 32'(press_cnt), 32'd1);
        chk("t2_valid", 32'(valid_n - b_valid), 32'd2);
        chk("t2_pops", 32'(pulses - b_pulses), 32'd5);

        // 3: extended key make and break
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0);
        push(8'hF0); push(8'h75);
        drain();
        chk("t3_code", 32'(key_code), 32'h75);
        chk("t3_ext", 32'(key_ext), 32'd1);
        chk("t3_cnt", 32'(press_cnt), 32'd1);
        chk("t3_down", 32'(key_down), 32'd0);
        chk("t3_valid", 32'(valid_n - b_valid), 32'd2);

        // 4: rollover then stale release
        do_reset();
        push(8'h1C); push(8'h32);
        drain();
        chk("t4_cnt", 32'(press_cnt), 32'd2);
        chk("t4_code", 32'(key_code), 32'h32);
        push(8'hF0); push(8'h1C);
        drain();
        chk("t4_down", 32'(key_down), 32'd1);
        chk("t4_valid", 32'(valid_n - b_valid), 32'd2);
        chk("t4_disp", 32'(disp_select), 32'h1F);

        // 5: overflow beats ready
        do_reset();
        push(8'h1C);
        drain();
        b_pulses = pulses;
        @(posedge clk);
        #1;
        mem[wr % 64] = 8'h55;
        wr++;
        kbd_overflow = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kbd_clrn && n < 20);
        chk("t5_clrn_seen", 32'(kbd_clrn), 32'd0);
        kbd_overflow = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_nopop", 32'(pulses - b_pulses), 32'd0);
        chk("t5_clrn_w", 32'(clrn_low - b_clrn), 32'd1);
        chk("t5_err", 32'(kbd_err), 32'd1);
        chk("t5_down", 32'(key_down), 32'd0);
        chk("t5_code", 32'(key_code), 32'h1C);
        chk("t5_cnt", 32'(press_cnt), 32'd1);

        // 6: counter wrap, then reset during POP
        do_reset();
        for (int i = 0; i < 255; i++) begin
            push(i[0] ? 8'h32 : 8'h1C);
            drain();
        end
        chk("t6_ff", 32'(press_cnt), 32'hFF);
        push(8'h44);
        drain();
        chk("t6_wrap", 32'(press_cnt), 32'h00);
        chk("t6_disp", 32'(disp_select), 32'h03);
        push(8'h2B);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kbd_nextdata_n && n < 20);
        chk("t6_inpop", 32'(kbd_nextdata_n), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6r_nd", 32'(kbd_nextdata_n), 32'd1);
        chk("t6r_clrn", 32'(kbd_clrn), 32'd0);
        chk("t6r_code", 32'(key_code), 32'h00);
        chk("t6r_ext", 32'(key_ext), 32'd0);
        chk("t6r_down", 32'(key_down), 32'd0);
        chk("t6r_valid", 32'(key_valid), 32'd0);
        chk("t6r_cnt", 32'(press_cnt), 32'd0);
        chk("t6r_err", 32'(kbd_err), 32'd0);
        chk("t6r_disp", 32'(disp_select), 32'h00);
        #4;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
